// File: rtl/dff_load_sequencer_if.sv
// dff_load_sequencer_if: load handshake plus serial data/strobe bus toward the register bank
interface dff_load_sequencer_if;
  logic       start;
  logic [7:0] byte_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic       bit_out;
  logic [7:0] strobe;
  modport master (output start, byte_in, input ready, busy, done, bit_out, strobe);
  modport slave  (input start, byte_in, output ready, busy, done, bit_out, strobe);
endinterface

// File: rtl/dff_load_sequencer.sv
// dff_load_sequencer: replays a latched byte as serial data plus one-hot per-flop clock strobes
module dff_load_sequencer #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input logic ff_clock,
  input logic rst,
  dff_load_sequencer_if.slave bus
);
  localparam int MAXP = (SETUP_CYCLES > PULSE_CYCLES) ?
                        ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                        ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAXP + 1);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] byte_q, byte_n, strobe_q, strobe_n;
  logic ready_q, busy_q, done_q, bit_q, bit_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    idx_n = idx;
    byte_n = byte_q;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.start) begin
          byte_n = bus.byte_in;
          idx_n = 3'd0;
          state_n = SETUP;
        end
      end
      SETUP: if (cnt == CW'(SETUP_CYCLES - 1)) begin
        cnt_n = '0;
        state_n = PULSE;
      end
      PULSE: if (cnt == CW'(PULSE_CYCLES - 1)) begin
        cnt_n = '0;
        state_n = HOLD;
      end
      HOLD: if (cnt == CW'(HOLD_CYCLES - 1)) begin
        cnt_n = '0;
        state_n = (idx == 3'd7) ? DONE : SETUP;
        idx_n = (idx == 3'd7) ? idx : idx + 3'd1;
      end
      default: begin
        cnt_n = '0;
        state_n = IDLE;
      end
    endcase
    // outputs are precomputed from the next state so every port is a plain flop
    strobe_n = (state_n == PULSE) ? (8'h80 >> idx_n) : 8'h00;
    bit_n = (state_n == SETUP) ? byte_n[idx_n] : bit_q;
  end
  always_ff @(posedge ff_clock or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= 3'd0;
      byte_q <= 8'h00;
      strobe_q <= 8'h00;
      bit_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      byte_q <= byte_n;
      strobe_q <= strobe_n;
      bit_q <= bit_n;
      ready_q <= state_n == IDLE;
      busy_q <= state_n == SETUP || state_n == PULSE || state_n == HOLD;
      done_q <= state_n == DONE;
    end
  assign bus.ready = ready_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bit_out = bit_q;
  assign bus.strobe = strobe_q;
endmodule

// File: tb/tb_dff_load_sequencer.sv
// tb_dff_load_sequencer: directed checks of the load sequencer with a behavioural register bank
module tb_dff_load_sequencer;
  logic ff_clock = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int fails = 0;
  logic [7:0] bank_a = 8'h00, bank_b = 8'h00, sa_prev, sb_prev;
  logic ba_prev, bb_prev;
  dff_load_sequencer_if a ();
  dff_load_sequencer_if b ();
  dff_load_sequencer dut_a (.ff_clock(ff_clock), .rst(rst), .bus(a.slave));
  dff_load_sequencer #(.SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(2))
    dut_b (.ff_clock(ff_clock), .rst(rst), .bus(b.slave));
  always #5 ff_clock = ~ff_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // bank model: each strobe rising edge captures bit_out into bank bit 7-k
  always @(negedge ff_clock) begin
    if (!rst) begin
      chk("onehot_a", 32'($countones(a.strobe) <= 1), 32'd1);
      chk("onehot_b", 32'($countones(b.strobe) <= 1), 32'd1);
      if (a.strobe !== sa_prev) chk("bit_stable_a", 32'(a.bit_out), 32'(ba_prev));
      if (b.strobe !== sb_prev) chk("bit_stable_b", 32'(b.bit_out), 32'(bb_prev));
      for (int k = 0; k < 8; k++) begin
        if (a.strobe[k] && !sa_prev[k]) bank_a[7-k] = a.bit_out;
        if (b.strobe[k] && !sb_prev[k]) bank_b[7-k] = b.bit_out;
      end
    end
    sa_prev = a.strobe;
    sb_prev = b.strobe;
    ba_prev = a.bit_out;
    bb_prev = b.bit_out;
  end

  // call right after the negedge on which start was raised with byte v
  task automatic run_a(input logic [7:0] v, input bit poke, input bit keep);
    for (int c = 0; c < 24; c++) begin
      @(negedge ff_clock);
      a.start = keep | (poke && c == 4);
      if (c == 0) a.byte_in = ~v;
      if (poke && c == 4) a.byte_in = 8'hFF;
      chk("busy", 32'(a.busy), 32'd1);
      chk("ready_busy", 32'(a.ready), 32'd0);
      chk("done_busy", 32'(a.done), 32'd0);
      chk("strobe", 32'(a.strobe), (c % 3 == 1) ? 32'(8'h80 >> (c / 3)) : 32'd0);
      chk("bit_out", 32'(a.bit_out), 32'(v[c / 3]));
    end
    @(negedge ff_clock);
    a.start = keep;
    chk("done", 32'(a.done), 32'd1);
    chk("busy_done", 32'(a.busy), 32'd0);
    chk("ready_done", 32'(a.ready), 32'd0);
    chk("strobe_done", 32'(a.strobe), 32'd0);
    chk("bit_done", 32'(a.bit_out), 32'(v[7]));
    @(negedge ff_clock);
    chk("ready_idle", 32'(a.ready), 32'd1);
    chk("done_idle", 32'(a.done), 32'd0);
    chk("busy_idle", 32'(a.busy), 32'd0);
    chk("bank_a", 32'(bank_a), 32'(v));
  endtask

  initial begin
    a.start = 1'b0; a.byte_in = 8'h00;
    b.start = 1'b0; b.byte_in = 8'h00;
    repeat (2) @(negedge ff_clock);
    rst = 1'b0;
    chk("rst_ready", 32'(a.ready), 32'd1);
    chk("rst_busy", 32'(a.busy), 32'd0);
    chk("rst_done", 32'(a.done), 32'd0);
    chk("rst_bit", 32'(a.bit_out), 32'd0);
    chk("rst_strobe", 32'(a.strobe), 32'd0);
    // basic load
    a.start = 1'b1; a.byte_in = 8'hA5;
    run_a(8'hA5, 1'b0, 1'b0);
    // start while busy is ignored
    a.start = 1'b1; a.byte_in = 8'hA5;
    run_a(8'hA5, 1'b1, 1'b0);
    // stretched phases: 2 setup, 3 pulse, 2 hold
    b.start = 1'b1; b.byte_in = 8'h3C;
    for (int c = 0; c < 56; c++) begin
      @(negedge ff_clock);
      b.start = 1'b0;
      chk("busy_b", 32'(b.busy), 32'd1);
      chk("strobe_b", 32'(b.strobe), (c % 7 >= 2 && c % 7 < 5) ? 32'(8'h80 >> (c / 7)) : 32'd0);
      chk("bit_b", 32'(b.bit_out), 32'(b.byte_in[c / 7] | 1'b0) & 32'(8'h3C >> (c / 7)) & 32'd1);
    end
    @(negedge ff_clock);
    chk("done_b", 32'(b.done), 32'd1);
    chk("busy_b_end", 32'(b.busy), 32'd0);
    chk("bank_b", 32'(bank_b), 32'h3C);
    // reset during the pulse of bit 3
    a.start = 1'b1; a.byte_in = 8'h17;
    for (int c = 0; c < 11; c++) begin
      @(negedge ff_clock);
      a.start = 1'b0;
    end
    chk("strobe_pre_rst", 32'(a.strobe), 32'h10);
    #1 rst = 1'b1;
    #1;
    chk("async_strobe", 32'(a.strobe), 32'd0);
    chk("async_bit", 32'(a.bit_out), 32'd0);
    chk("async_ready", 32'(a.ready), 32'd1);
    chk("async_busy", 32'(a.busy), 32'd0);
    @(negedge ff_clock);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ff_clock);
      chk("quiet_strobe", 32'(a.strobe), 32'd0);
      chk("quiet_ready", 32'(a.ready), 32'd1);
    end
    // start held high: two back-to-back loads
    a.start = 1'b1; a.byte_in = 8'h00;
    run_a(8'h00, 1'b0, 1'b1);
    run_a(8'hFF, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
